// File: rtl/entity_selector_if.sv
// entity_selector_if: pixel/game-state bundle between the video timing side and
// the entity selector, plus the resolved-entity results fed to the color mapper.
// Latency: n/a (wires only). Backpressure: none, the pixel stream never stalls.
// Ports (master = scan/game side, slave = entity_selector):
//   VGA_VS, DrawX, DrawY, pellet_present, obj_x/obj_y/obj_dir/obj_en, lose_game -> slave
//   entity, spriteAddrX/Y, mazeAddrX/Y, direction, frame_tick                  -> master
interface entity_selector_if;
  logic        VGA_VS;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        pellet_present;
  logic [49:0] obj_x;
  logic [49:0] obj_y;
  logic [9:0]  obj_dir;
  logic [4:0]  obj_en;
  logic        lose_game;

  logic [6:0]  entity;
  logic [9:0]  spriteAddrX;
  logic [9:0]  spriteAddrY;
  logic [9:0]  mazeAddrX;
  logic [9:0]  mazeAddrY;
  logic [1:0]  direction;
  logic        frame_tick;

  modport master (
    output VGA_VS, DrawX, DrawY, pellet_present, obj_x, obj_y, obj_dir, obj_en, lose_game,
    input  entity, spriteAddrX, spriteAddrY, mazeAddrX, mazeAddrY, direction, frame_tick
  );

  modport slave (
    input  VGA_VS, DrawX, DrawY, pellet_present, obj_x, obj_y, obj_dir, obj_en, lose_game,
    output entity, spriteAddrX, spriteAddrY, mazeAddrX, mazeAddrY, direction, frame_tick
  );
endinterface

// File: rtl/entity_selector.sv
// entity_selector: per-pixel resolver choosing which entity covers (DrawX,DrawY).
// Latency: every output registered, 1 Clk after the pixel it describes; one pixel per cycle.
// Backpressure: none; object state is snapshotted on the VGA_VS falling edge.
// Ports: Clk, Reset (sync, active-high), bus (entity_selector_if.slave):
//   inputs  pixel coords, pellet flag, packed object x/y/dir/en (pacman in slot 0), lose_game
//   outputs entity code, sprite-relative and maze-relative addresses, direction, frame_tick
module entity_selector #(
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter int MAZE_X0  = 208,
  parameter int MAZE_Y0  = 116,
  parameter int MAZE_W   = 224,
  parameter int MAZE_H   = 248
) (
  input  logic                Clk,
  input  logic                Reset,
  entity_selector_if.slave    bus
);

  localparam int NOBJ   = 5;
  localparam int SW_BITS = $clog2(SPRITE_W);
  localparam int SH_BITS = $clog2(SPRITE_H);

  // Entity codes; object slot 0 is pacman, slots 1..4 are blinky..clyde.
  localparam logic [6:0] ENT_NONE   = 7'd0;
  localparam logic [6:0] ENT_PACMAN = 7'd1;
  localparam logic [6:0] ENT_BG     = 7'd2;
  localparam logic [6:0] ENT_PELLET = 7'd7;

  // Frame-consistent copy of the game state.
  logic       r_vs_d;
  logic [9:0] r_x   [NOBJ];
  logic [9:0] r_y   [NOBJ];
  logic [1:0] r_dir [NOBJ];
  logic [4:0] r_en;
  logic       r_lose;

  // Registered outputs.
  logic [6:0] r_entity;
  logic [9:0] r_spr_x;
  logic [9:0] r_spr_y;
  logic [9:0] r_maze_x;
  logic [9:0] r_maze_y;
  logic [1:0] r_direction;
  logic       r_frame_tick;

  logic        w_vs_fall;
  logic [10:0] w_dx  [NOBJ];
  logic [10:0] w_dy  [NOBJ];
  logic [NOBJ-1:0] w_hit;
  logic        w_in_maze;
  logic [2:0]  w_sel;
  logic        w_sel_vld;
  logic [6:0]  w_entity;
  logic [9:0]  w_spr_x;
  logic [9:0]  w_spr_y;
  logic [9:0]  w_maze_x;
  logic [9:0]  w_maze_y;
  logic [1:0]  w_direction;

  function automatic logic [6:0] code_of(input int i);
    return (i == 0) ? ENT_PACMAN : 7'(i + 2);
  endfunction

  assign w_vs_fall = r_vs_d & ~bus.VGA_VS;

  // Hit test in 11 bits: a sprite hanging off the right/bottom edge must not
  // alias onto column/row 0, so DrawX < x is rejected before the width test.
  always_comb begin
    for (int i = 0; i < NOBJ; i++) begin
      w_dx[i]  = {1'b0, bus.DrawX} - {1'b0, r_x[i]};
      w_dy[i]  = {1'b0, bus.DrawY} - {1'b0, r_y[i]};
      w_hit[i] = r_en[i]
                 && (bus.DrawX >= r_x[i]) && (w_dx[i] < 11'(SPRITE_W))
                 && (bus.DrawY >= r_y[i]) && (w_dy[i] < 11'(SPRITE_H));
    end
  end

  assign w_in_maze = ({1'b0, bus.DrawX} >= 11'(MAZE_X0))
                  && ({1'b0, bus.DrawX} <  11'(MAZE_X0 + MAZE_W))
                  && ({1'b0, bus.DrawY} >= 11'(MAZE_Y0))
                  && ({1'b0, bus.DrawY} <  11'(MAZE_Y0 + MAZE_H));

  // Priority resolve: walk lowest priority first so the highest-priority hit
  // (lowest slot index) is the last writer. Ghosts and pellets vanish during
  // the death sequence.
  always_comb begin
    w_sel       = 3'd0;
    w_sel_vld   = 1'b0;
    w_entity    = ENT_NONE;
    w_spr_x     = '0;
    w_spr_y     = '0;
    w_direction = 2'd0;
    w_maze_x    = '0;
    w_maze_y    = '0;

    if (w_in_maze) begin
      w_maze_x = bus.DrawX - 10'(MAZE_X0);
      w_maze_y = bus.DrawY - 10'(MAZE_Y0);
      w_entity = (bus.pellet_present && !r_lose) ? ENT_PELLET : ENT_BG;
    end

    for (int i = NOBJ - 1; i >= 0; i--) begin
      if (w_hit[i] && (i == 0 || !r_lose)) begin
        w_sel     = 3'(i);
        w_sel_vld = 1'b1;
        w_entity  = code_of(i);
      end
    end

    if (w_sel_vld) begin
      w_spr_x[SW_BITS-1:0] = w_dx[w_sel][SW_BITS-1:0];
      w_spr_y[SH_BITS-1:0] = w_dy[w_sel][SH_BITS-1:0];
      w_direction          = r_dir[w_sel];
    end
  end

  // The pixel registered on the snapshot edge still sees the old shadow state,
  // since the shadow registers update on that same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_vs_d       <= 1'b1;
      r_en         <= '0;
      r_lose       <= 1'b0;
      for (int i = 0; i < NOBJ; i++) begin
        r_x[i]   <= '0;
        r_y[i]   <= '0;
        r_dir[i] <= '0;
      end
      r_entity     <= '0;
      r_spr_x      <= '0;
      r_spr_y      <= '0;
      r_maze_x     <= '0;
      r_maze_y     <= '0;
      r_direction  <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_vs_d       <= bus.VGA_VS;
      r_frame_tick <= w_vs_fall;
      if (w_vs_fall) begin
        r_en   <= bus.obj_en;
        r_lose <= bus.lose_game;
        for (int i = 0; i < NOBJ; i++) begin
          r_x[i]   <= bus.obj_x[i*10 +: 10];
          r_y[i]   <= bus.obj_y[i*10 +: 10];
          r_dir[i] <= bus.obj_dir[i*2 +: 2];
        end
      end
      r_entity    <= w_entity;
      r_spr_x     <= w_spr_x;
      r_spr_y     <= w_spr_y;
      r_maze_x    <= w_maze_x;
      r_maze_y    <= w_maze_y;
      r_direction <= w_direction;
    end
  end

  assign bus.entity      = r_entity;
  assign bus.spriteAddrX = r_spr_x;
  assign bus.spriteAddrY = r_spr_y;
  assign bus.mazeAddrX   = r_maze_x;
  assign bus.mazeAddrY   = r_maze_y;
  assign bus.direction   = r_direction;
  assign bus.frame_tick  = r_frame_tick;

endmodule

// File: tb/tb_entity_selector.sv
// tb_entity_selector: directed bench for entity_selector with an expected-result queue.
// Latency: expects each pixel's result 1 Clk after it is driven.
// Backpressure: none; one pixel driven per step, vsync edges driven explicitly.
module tb_entity_selector;

  typedef struct packed {
    logic [6:0] ent;
    logic [9:0] sx;
    logic [9:0] sy;
    logic [9:0] mx;
    logic [9:0] my;
    logic [1:0] dir;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  entity_selector_if bus();

  entity_selector dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int n_cmp  = 0;
  int n_fail = 0;
  exp_t sb[$];

  // Values presented on the object inputs.
  int   tb_x[5], tb_y[5], tb_dir[5];
  logic [4:0] tb_en;
  logic tb_lose;
  // Model of the frame snapshot held by the DUT.
  int   m_x[5], m_y[5], m_dir[5];
  logic [4:0] m_en;
  logic m_lose;
  int   codes[5] = '{1, 3, 4, 5, 6};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int k = 0; k < 5; k++) begin
      bus.obj_x[k*10 +: 10] = 10'(tb_x[k]);
      bus.obj_y[k*10 +: 10] = 10'(tb_y[k]);
      bus.obj_dir[k*2 +: 2] = 2'(tb_dir[k]);
    end
    bus.obj_en    = tb_en;
    bus.lose_game = tb_lose;
  endtask

  task automatic set_obj(input int k, input int x, input int y, input int d);
    tb_x[k] = x; tb_y[k] = y; tb_dir[k] = d;
  endtask

  task automatic take_model();
    for (int k = 0; k < 5; k++) begin
      m_x[k] = tb_x[k]; m_y[k] = tb_y[k]; m_dir[k] = tb_dir[k];
    end
    m_en = tb_en; m_lose = tb_lose;
  endtask

  function automatic exp_t model(input int x, input int y, input bit pel);
    exp_t e;
    bit   in_maze;
    e = '0;
    in_maze = (x >= 208) && (x < 432) && (y >= 116) && (y < 364);
    if (in_maze) begin
      e.mx  = 10'(x - 208);
      e.my  = 10'(y - 116);
      e.ent = (pel && !m_lose) ? 7'd7 : 7'd2;
    end
    for (int k = 4; k >= 0; k--) begin
      if (m_en[k] && (k == 0 || !m_lose) &&
          x >= m_x[k] && x < m_x[k] + 16 && y >= m_y[k] && y < m_y[k] + 16) begin
        e.ent = 7'(codes[k]);
        e.sx  = 10'(x - m_x[k]);
        e.sy  = 10'(y - m_y[k]);
        e.dir = 2'(m_dir[k]);
      end
    end
    return e;
  endfunction

  task automatic check_out(input int exp_ent);
    exp_t e;
    e = sb.pop_front();
    chk("entity",      32'(bus.entity),      32'(e.ent));
    chk("spriteAddrX", 32'(bus.spriteAddrX), 32'(e.sx));
    chk("spriteAddrY", 32'(bus.spriteAddrY), 32'(e.sy));
    chk("mazeAddrX",   32'(bus.mazeAddrX),   32'(e.mx));
    chk("mazeAddrY",   32'(bus.mazeAddrY),   32'(e.my));
    chk("direction",   32'(bus.direction),   32'(e.dir));
    if (exp_ent >= 0) chk("entity_plan", 32'(bus.entity), 32'(exp_ent));
  endtask

  task automatic pix(input int x, input int y, input bit pel, input int exp_ent);
    @(negedge Clk);
    bus.DrawX = 10'(x); bus.DrawY = 10'(y); bus.pellet_present = pel;
    sb.push_back(model(x, y, pel));
    @(posedge Clk); #1;
    check_out(exp_ent);
  endtask

  // Falling vsync together with a pixel: that pixel resolves against the old snapshot.
  task automatic snap_pix(input int x, input int y, input int exp_ent);
    @(negedge Clk);
    bus.VGA_VS = 1'b0;
    bus.DrawX = 10'(x); bus.DrawY = 10'(y); bus.pellet_present = 1'b0;
    sb.push_back(model(x, y, 1'b0));
    @(posedge Clk); #1;
    check_out(exp_ent);
    take_model();
    chk("tick_on", 32'(bus.frame_tick), 32'd1);
    @(negedge Clk);
    bus.VGA_VS = 1'b1;
    @(posedge Clk); #1;
    chk("tick_off", 32'(bus.frame_tick), 32'd0);
  endtask

  task automatic snap();
    snap_pix(0, 0, 0);
  endtask

  initial begin
    int ticks;
    Reset = 1'b1;
    bus.VGA_VS = 1'b1;
    bus.DrawX = '0; bus.DrawY = '0; bus.pellet_present = 1'b0;
    for (int k = 0; k < 5; k++) set_obj(k, 0, 0, 0);
    tb_en = '0; tb_lose = 1'b0;
    apply();
    take_model();

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_entity",     32'(bus.entity),      32'd0);
    chk("rst_mazeAddrX",  32'(bus.mazeAddrX),   32'd0);
    chk("rst_spriteAddrX",32'(bus.spriteAddrX), 32'd0);
    chk("rst_frame_tick", 32'(bus.frame_tick),  32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // Pacman alone
    set_obj(0, 300, 200, 3); tb_en = 5'b00001; apply();
    snap();
    pix(305, 210, 0, 1);
    chk("plan_sprite_x", 32'(bus.spriteAddrX), 32'd5);
    chk("plan_maze_y",   32'(bus.mazeAddrY),   32'd94);

    // Blinky over pinky at the same spot
    set_obj(1, 300, 200, 2); set_obj(2, 300, 200, 1); tb_en = 5'b00110; apply();
    snap();
    pix(300, 200, 0, 3);
    pix(316, 200, 0, 2);

    // Edge sprites must not wrap
    set_obj(0, 630, 470, 0); tb_en = 5'b00001; apply();
    snap();
    pix(2, 475, 0, 0);
    pix(639, 475, 0, 1);
    pix(635, 3, 0, 0);
    pix(639, 479, 0, 1);

    // Mid-frame changes ignored until the next vsync edge
    set_obj(0, 300, 200, 1); apply();
    snap();
    set_obj(0, 350, 200, 1); apply();
    pix(305, 210, 0, 1);
    pix(355, 210, 0, 2);
    snap();
    pix(305, 210, 0, 2);
    pix(355, 210, 0, 1);

    // VS held low: exactly one tick
    @(negedge Clk);
    bus.VGA_VS = 1'b0;
    ticks = 0;
    repeat (1000) begin
      @(posedge Clk); #1;
      ticks += int'(bus.frame_tick);
    end
    chk("vs_low_ticks", 32'(ticks), 32'd1);
    take_model();
    @(negedge Clk);
    bus.VGA_VS = 1'b1;
    @(posedge Clk);

    // Death sequence masks ghosts and pellets
    set_obj(0, 300, 200, 3); set_obj(1, 350, 250, 2); tb_en = 5'b00011; tb_lose = 1'b1; apply();
    snap();
    pix(355, 255, 0, 2);
    pix(400, 300, 1, 2);
    pix(305, 205, 0, 1);

    // Pellets and outside-maze pixels
    tb_lose = 1'b0; apply();
    snap();
    pix(355, 255, 0, 3);
    pix(400, 300, 1, 7);
    pix(100, 100, 0, 0);
    pix(100, 100, 1, 0);

    // Reset mid-frame clears outputs and the snapshot
    @(negedge Clk);
    Reset = 1'b1;
    bus.DrawX = 10'd305; bus.DrawY = 10'd205; bus.pellet_present = 1'b0;
    @(posedge Clk); #1;
    chk("midrst_entity",    32'(bus.entity),    32'd0);
    chk("midrst_mazeAddrX", 32'(bus.mazeAddrX), 32'd0);
    for (int k = 0; k < 5; k++) begin
      m_x[k] = 0; m_y[k] = 0; m_dir[k] = 0;
    end
    m_en = '0; m_lose = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    pix(305, 205, 0, 2);
    pix(400, 300, 1, 7);
    snap_pix(305, 205, 2);
    pix(305, 205, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
